// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl: command sequencer driving an external 32-bit ALU, with single-cycle ops and a shift-add unsigned multiply.
module alu_seq_ctrl #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic [WIDTH-1:0] rsp_hi,
    output logic             rsp_carry,
    output logic             rsp_err,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [1:0]       alu_op,
    output logic             alu_binvert,
    output logic             alu_cin,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_cout
);
    typedef enum logic [1:0] {IDLE, EXEC, MUL_ITER, RESP} state_t;
    state_t           r_state;
    logic             r_addsub;
    logic [WIDTH-1:0] r_q;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_alu_a;
    logic [WIDTH-1:0] r_alu_b;
    logic [1:0]       r_alu_op;
    logic             r_binv;
    logic             r_cin;
    logic             r_rsp_valid;
    logic [WIDTH-1:0] r_rsp_data;
    logic [WIDTH-1:0] r_rsp_hi;
    logic             r_rsp_carry;
    logic             r_rsp_err;
    logic [WIDTH:0]   w_acc;
    logic [WIDTH-1:0] w_p_next;
    logic [WIDTH-1:0] w_q_next;
    // During multiply r_alu_a doubles as the partial-product accumulator P.
    assign w_acc    = r_q[0] ? {alu_cout, alu_result} : {1'b0, r_alu_a};
    assign w_p_next = w_acc[WIDTH:1];
    assign w_q_next = {w_acc[0], r_q[WIDTH-1:1]};
    assign cmd_ready   = (r_state == IDLE);
    assign rsp_valid   = r_rsp_valid;
    assign rsp_data    = r_rsp_data;
    assign rsp_hi      = r_rsp_hi;
    assign rsp_carry   = r_rsp_carry;
    assign rsp_err     = r_rsp_err;
    assign alu_a       = r_alu_a;
    assign alu_b       = r_alu_b;
    assign alu_op      = r_alu_op;
    assign alu_binvert = r_binv;
    assign alu_cin     = r_cin;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_addsub    <= 1'b0;
            r_q         <= '0;
            r_cnt       <= '0;
            r_alu_a     <= '0;
            r_alu_b     <= '0;
            r_alu_op    <= 2'b00;
            r_binv      <= 1'b0;
            r_cin       <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_hi    <= '0;
            r_rsp_carry <= 1'b0;
            r_rsp_err   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (cmd_valid) begin
                    if (!cmd_op[2]) begin
                        r_state  <= EXEC;
                        r_addsub <= cmd_op[1];
                        r_alu_a  <= cmd_a;
                        r_alu_b  <= cmd_b;
                        r_alu_op <= cmd_op[1] ? 2'b10 : cmd_op[1:0];
                        r_binv   <= (cmd_op == 3'd3);
                        r_cin    <= (cmd_op == 3'd3);
                    end else if (cmd_op == 3'd4) begin
                        r_state  <= MUL_ITER;
                        r_q      <= cmd_a;
                        r_cnt    <= '0;
                        r_alu_a  <= '0;
                        r_alu_b  <= cmd_b;
                        r_alu_op <= 2'b10;
                        r_binv   <= 1'b0;
                        r_cin    <= 1'b0;
                    end else begin
                        r_state     <= RESP;
                        r_rsp_err   <= 1'b1;
                        r_rsp_data  <= '0;
                        r_rsp_hi    <= '0;
                        r_rsp_carry <= 1'b0;
                    end
                end
                EXEC: begin
                    r_state     <= RESP;
                    r_rsp_data  <= alu_result;
                    r_rsp_carry <= r_addsub & alu_cout;
                    r_rsp_hi    <= '0;
                    r_rsp_err   <= 1'b0;
                    r_alu_a     <= '0;
                    r_alu_b     <= '0;
                    r_alu_op    <= 2'b00;
                    r_binv      <= 1'b0;
                    r_cin       <= 1'b0;
                end
                MUL_ITER: begin
                    r_alu_a <= w_p_next;
                    r_q     <= w_q_next;
                    r_cnt   <= r_cnt + 1'b1;
                    if (r_cnt == CNT_W'(WIDTH - 1)) begin
                        r_state     <= RESP;
                        r_rsp_hi    <= w_p_next;
                        r_rsp_data  <= w_q_next;
                        r_rsp_carry <= 1'b0;
                        r_rsp_err   <= 1'b0;
                        r_q         <= '0;
                        r_alu_a     <= '0;
                        r_alu_b     <= '0;
                        r_alu_op    <= 2'b00;
                    end
                end
                RESP: begin
                    // Valid rises one cycle after entering RESP, then waits for the consumer.
                    if (!r_rsp_valid) r_rsp_valid <= 1'b1;
                    else if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule
